// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART oversample tick and bit tick generator.
// Double-buffered runtime divisor; optional fractional divisor under BAUD_FRAC_EN.
module baud_tick_gen #(
    parameter int WIDTH      = 8,
    parameter int RESET_DIV  = 163,
    parameter int OVERSAMPLE = 16,
    parameter int FRAC_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          div_wr,
    input  logic [WIDTH-1:0]              div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_WIDTH-1:0]         frac_in,
`endif
    output logic [WIDTH-1:0]              count,
    output logic                          tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_count,
    output logic                          bit_tick,
    output logic                          div_pend
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLE - 1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic             bit_q, bit_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_sh_q, div_sh_d;
    logic             pend_q, pend_d;

    logic [WIDTH-1:0] modulus;
    logic [WIDTH:0]   last;
    logic             wrap;
    logic             frac_carry;

`ifdef BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] frac_act_q, frac_act_d;
    logic [FRAC_WIDTH-1:0] frac_sh_q, frac_sh_d;
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic [FRAC_WIDTH-1:0] frac_sum;

    // Carry of this period's accumulation stretches the period by one cycle
    always_comb begin
        {frac_carry, frac_sum} = {1'b0, acc_q} + {1'b0, frac_act_q};
        acc_d = acc_q;
        if (wrap) begin
            acc_d = frac_sum;
        end
    end
`else
    localparam logic [FRAC_WIDTH:0] NO_FRAC = '0;
    assign frac_carry = NO_FRAC[FRAC_WIDTH];
`endif

    // Effective modulus and period-end detect; divisors 0/1 behave as 2
    always_comb begin
        modulus = div_act_q;
        if (div_act_q < WIDTH'(2)) begin
            modulus = WIDTH'(2);
        end
        last = {1'b0, modulus} - (WIDTH+1)'(1) + {{WIDTH{1'b0}}, frac_carry};
        wrap = en && ({1'b0, count_q} >= last);
    end

    // Main counter and oversample stage
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        os_d    = os_q;
        bit_d   = 1'b0;
        if (wrap) begin
            count_d = '0;
            tick_d  = 1'b1;
            bit_d   = (os_q == OS_MAX);
            os_d    = (os_q == OS_MAX) ? '0 : os_q + OS_W'(1);
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Shadow/active divisor; idle or period-end writes bypass the shadow
    always_comb begin
        div_act_d = div_act_q;
        div_sh_d  = div_sh_q;
        pend_d    = pend_q;
`ifdef BAUD_FRAC_EN
        frac_act_d = frac_act_q;
        frac_sh_d  = frac_sh_q;
`endif
        if (div_wr && (!en || wrap)) begin
            div_act_d = div_in;
            div_sh_d  = div_in;
            pend_d    = 1'b0;
`ifdef BAUD_FRAC_EN
            frac_act_d = frac_in;
            frac_sh_d  = frac_in;
`endif
        end else if (wrap) begin
            div_act_d = div_sh_q;
            pend_d    = 1'b0;
`ifdef BAUD_FRAC_EN
            frac_act_d = frac_sh_q;
`endif
        end else if (div_wr) begin
            div_sh_d = div_in;
            pend_d   = 1'b1;
`ifdef BAUD_FRAC_EN
            frac_sh_d = frac_in;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= '0;
            tick_q    <= 1'b0;
            os_q      <= '0;
            bit_q     <= 1'b0;
            div_act_q <= DIV_RST;
            div_sh_q  <= DIV_RST;
            pend_q    <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_act_q <= '0;
            frac_sh_q  <= '0;
            acc_q      <= '0;
`endif
        end else begin
            count_q   <= count_d;
            tick_q    <= tick_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            div_act_q <= div_act_d;
            div_sh_q  <= div_sh_d;
            pend_q    <= pend_d;
`ifdef BAUD_FRAC_EN
            frac_act_q <= frac_act_d;
            frac_sh_q  <= frac_sh_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign os_count = os_q;
    assign bit_tick = bit_q;
    assign div_pend = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed stimulus with a tick-time scoreboard.
// Expected tick / bit_tick cycles are queued as stimulus is applied.
module tb_baud_tick_gen;

    localparam int W  = 8;
    localparam int RD = 163;
    localparam int OS = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          div_wr = 1'b0;
    logic [W-1:0]  div_in = '0;
    logic [FW-1:0] frac_in = '0;
    logic [W-1:0]  count;
    logic          tick;
    logic [3:0]    os_count;
    logic          bit_tick;
    logic          div_pend;

    baud_tick_gen #(
        .WIDTH(W), .RESET_DIV(RD), .OVERSAMPLE(OS), .FRAC_WIDTH(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .div_wr(div_wr),
        .div_in(div_in),
`ifdef BAUD_FRAC_EN
        .frac_in(frac_in),
`endif
        .count(count),
        .tick(tick),
        .os_count(os_count),
        .bit_tick(bit_tick),
        .div_pend(div_pend)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tq[$];
    int bq[$];
    bit mon_on = 1'b0;
    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        mon_on = 1'b0;
        chk("tick_q_empty", tq.size(), 0);
        chk("bit_q_empty", bq.size(), 0);
        tq.delete();
        bq.delete();
    endtask

    task automatic do_reset(input logic en_after, output int e0);
        mon_on = 1'b0;
        rst = 1'b0;
        en = 1'b0;
        div_wr = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_tick", tick, 0);
        chk("rst_os", os_count, 0);
        chk("rst_bit", bit_tick, 0);
        chk("rst_pend", div_pend, 0);
        rst = 1'b1;
        en = en_after;
        e0 = cyc;
        mon_on = 1'b1;
    endtask

    // Scoreboard: each observed tick pops its expected cycle number
    always @(negedge clk) begin
        if (mon_on && tick) begin
            chk("tick_expected", tq.size() > 0, 1);
            if (tq.size() > 0) chk("tick_cycle", cyc, tq.pop_front());
        end
        if (mon_on && bit_tick) begin
            chk("bit_expected", bq.size() > 0, 1);
            if (bq.size() > 0) chk("bit_cycle", cyc, bq.pop_front());
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cyc=%0d limit=5ms", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int e1;
        int t;

        // Free-running default divisor
        do_reset(1'b1, e0);
        for (int k = 1; k <= 16; k++) tq.push_back(e0 + RD * k);
        bq.push_back(e0 + RD * OS);
        for (int k = 0; k < 16; k++) begin
            step(RD);
            chk("p1_pend", div_pend, 0);
        end
        step(2);
        flush();

        // Divisor write mid-period lands at the period end
        do_reset(1'b1, e0);
        for (int j = 0; j < 16; j++) tq.push_back(e0 + RD + 10 * j);
        bq.push_back(e0 + RD + 150);
        step(50);
        chk("p2_count50", count, 50);
        div_in = 8'd10;
        div_wr = 1'b1;
        step(1);
        div_wr = 1'b0;
        chk("p2_pend_set", div_pend, 1);
        chk("p2_os_hold", os_count, 0);
        step(111);
        chk("p2_count162", count, 162);
        chk("p2_pend_162", div_pend, 1);
        step(1);
        chk("p2_pend_clr", div_pend, 0);
        chk("p2_os1", os_count, 1);
        chk("p2_wrap_count", count, 0);
        step(10);
        chk("p2_os2", os_count, 2);
        step(142);
        flush();

        // Enable held low mid-period
        do_reset(1'b1, e0);
        step(5);
        chk("p3_count5", count, 5);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("p3_hold", count, 5);
            chk("p3_tick0", tick, 0);
        end
        en = 1'b1;
        e1 = cyc;
        tq.push_back(e1 + 158);
        step(160);
        flush();

        // Divisors 0 and 1 clamp to 2, applied while idle
        do_reset(1'b0, e0);
        div_in = 8'd0;
        div_wr = 1'b1;
        step(1);
        div_wr = 1'b0;
        chk("p4_pend0", div_pend, 0);
        div_in = 8'd1;
        div_wr = 1'b1;
        step(1);
        div_wr = 1'b0;
        chk("p4_pend1", div_pend, 0);
        en = 1'b1;
        e1 = cyc;
        for (int k = 1; k <= 32; k++) tq.push_back(e1 + 2 * k);
        bq.push_back(e1 + 32);
        bq.push_back(e1 + 64);
        step(65);
        flush();

        // Reset while a divisor change is pending
        do_reset(1'b1, e0);
        step(20);
        div_in = 8'd10;
        div_wr = 1'b1;
        step(1);
        div_wr = 1'b0;
        chk("p5_pend", div_pend, 1);
        mon_on = 1'b0;
        rst = 1'b0;
        step(1);
        chk("p5_count", count, 0);
        chk("p5_tick", tick, 0);
        chk("p5_os", os_count, 0);
        chk("p5_bit", bit_tick, 0);
        chk("p5_pend0", div_pend, 0);
        rst = 1'b1;
        e1 = cyc;
        tq.push_back(e1 + RD);
        tq.push_back(e1 + 2 * RD);
        mon_on = 1'b1;
        step(330);
        flush();

`ifdef BAUD_FRAC_EN
        // Fractional divisor 4.5: periods alternate 4 and 5
        do_reset(1'b0, e0);
        div_in = 8'd4;
        frac_in = 4'd8;
        div_wr = 1'b1;
        step(1);
        div_wr = 1'b0;
        en = 1'b1;
        e1 = cyc;
        t = 0;
        for (int k = 1; k <= 16; k++) begin
            t += (k % 2 == 1) ? 4 : 5;
            tq.push_back(e1 + t);
        end
        bq.push_back(e1 + 72);
        step(73);
        flush();
`else
        t = 0;
`endif

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
